local_port_sa_scheduler: RTL and testbench

Per-router scheduler for the local injection ports. Each cycle it computes the XY look-ahead output direction of every requesting local-port head flit and arbitrates the four mesh output directions (N, S, E, W) among the local requesters, using round-robin. It holds each grant for the whole packet and never issues a flit without a downstream credit. It sits between the local-port input buffers and the router crossbar's local-input slice; winning flits leave through a registered per-direction select.

---
 rtl/rvh_noc_pkg.sv | 30 +++
 rtl/local_port_look_adead_routing.sv | 20 ++
 rtl/rr_arb.sv | 29 ++
 rtl/local_port_sa_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_local_port_sa_scheduler.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rvh_noc_pkg.sv
// Shared NoC types: mesh direction indices, coordinate and port-index widths,
// and the per-direction packet lock states.
package rvh_noc_pkg;

    localparam int NodeID_X_Width     = 2;
    localparam int NodeID_Y_Width     = 2;
    localparam int LocalPortIdx_Width = 2;
    localparam int DIR_NUM            = 4;

    typedef enum logic [1:0] {
        N = 2'd0,
        S = 2'd1,
        E = 2'd2,
        W = 2'd3
    } io_port_t;

    typedef logic lock_state_t;
    localparam lock_state_t IDLE   = 1'b0;
    localparam lock_state_t LOCKED = 1'b1;

    // Round-robin successor of a winning index among num requesters.
    function automatic logic [LocalPortIdx_Width-1:0] rr_next(
        input logic [LocalPortIdx_Width-1:0] idx,
        input int                            num
    );
        if (int'(idx) >= num - 1) return '0;
        return idx + LocalPortIdx_Width'(1);
    endfunction

endpackage

// File: rtl/local_port_look_adead_routing.sv
// XY look-ahead route for a local-port head flit; X is resolved first and a
// same-router target falls through to S, so the result is always a mesh port.
module local_port_look_adead_routing
    import rvh_noc_pkg::*;
(
    input  logic [NodeID_X_Width-1:0] node_id_x_src_i,
    input  logic [NodeID_Y_Width-1:0] node_id_y_src_i,
    input  logic [NodeID_X_Width-1:0] node_id_x_tgt_i,
    input  logic [NodeID_Y_Width-1:0] node_id_y_tgt_i,
    output logic [1:0]                look_ahead_routing_o
);

    always_comb begin
        if (node_id_x_src_i < node_id_x_tgt_i)      look_ahead_routing_o = E;
        else if (node_id_x_src_i > node_id_x_tgt_i) look_ahead_routing_o = W;
        else if (node_id_y_src_i < node_id_y_tgt_i) look_ahead_routing_o = N;
        else                                        look_ahead_routing_o = S;
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with an externally held priority pointer; the first
// requester at or after ptr_i (wrapping) wins.
module rr_arb #(
    parameter int WIDTH = 2,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int k = 0; k < WIDTH; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (!gnt_vld_o && req_i[j] && (((int'(ptr_i) + k) % WIDTH) == j)) begin
                    gnt_vld_o = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/local_port_sa_scheduler.sv
// Local-port switch-allocation scheduler: routes head flits, arbitrates each
// mesh direction round-robin, holds grants per packet and tracks credits.
module local_port_sa_scheduler
    import rvh_noc_pkg::*;
#(
    parameter int LOCAL_PORT_NUM = 2,
    parameter int CREDIT_DEPTH   = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [NodeID_X_Width-1:0]                node_id_x_src_i,
    input  logic [NodeID_Y_Width-1:0]                node_id_y_src_i,
    input  logic [LOCAL_PORT_NUM-1:0]                req_vld_i,
    input  logic [LOCAL_PORT_NUM-1:0]                req_head_i,
    input  logic [LOCAL_PORT_NUM-1:0]                req_tail_i,
    input  logic [LOCAL_PORT_NUM*NodeID_X_Width-1:0] req_tgt_x_i,
    input  logic [LOCAL_PORT_NUM*NodeID_Y_Width-1:0] req_tgt_y_i,
    output logic [LOCAL_PORT_NUM-1:0]                req_rdy_o,
    input  logic [DIR_NUM-1:0]                       credit_rtn_i,
    output logic [DIR_NUM-1:0]                       out_vld_o,
    output logic [DIR_NUM*LocalPortIdx_Width-1:0]    out_sel_o
);

    localparam int CRD_W = $clog2(CREDIT_DEPTH + 1);
    localparam int IDX_W = LocalPortIdx_Width;
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDIT_DEPTH);
    localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

    logic [LOCAL_PORT_NUM-1:0][1:0] head_dir;
    logic [LOCAL_PORT_NUM-1:0][1:0] cur_dir;
    logic [LOCAL_PORT_NUM-1:0]      has_route;

    logic [LOCAL_PORT_NUM-1:0]      route_vld_q, route_vld_d;
    logic [LOCAL_PORT_NUM-1:0][1:0] route_dir_q, route_dir_d;

    lock_state_t [DIR_NUM-1:0]      lock_q, lock_d;
    logic [DIR_NUM-1:0][IDX_W-1:0]  owner_q, owner_d;
    logic [DIR_NUM-1:0][IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DIR_NUM-1:0][CRD_W-1:0]  credit_q, credit_d;
    logic [DIR_NUM-1:0]             out_vld_q, out_vld_d;
    logic [DIR_NUM-1:0][IDX_W-1:0]  out_sel_q, out_sel_d;

    logic [DIR_NUM-1:0][LOCAL_PORT_NUM-1:0] elig;
    logic [DIR_NUM-1:0][LOCAL_PORT_NUM-1:0] gnt;
    logic [DIR_NUM-1:0]                     gnt_vld;
    logic [DIR_NUM-1:0][IDX_W-1:0]          gnt_idx;
    logic [DIR_NUM-1:0]                     win_head;
    logic [DIR_NUM-1:0]                     win_tail;

    for (genvar gi = 0; gi < LOCAL_PORT_NUM; gi++) begin : g_route
        local_port_look_adead_routing u_route (
            .node_id_x_src_i      (node_id_x_src_i),
            .node_id_y_src_i      (node_id_y_src_i),
            .node_id_x_tgt_i      (req_tgt_x_i[gi*NodeID_X_Width +: NodeID_X_Width]),
            .node_id_y_tgt_i      (req_tgt_y_i[gi*NodeID_Y_Width +: NodeID_Y_Width]),
            .look_ahead_routing_o (head_dir[gi])
        );
        assign cur_dir[gi]   = req_head_i[gi] ? head_dir[gi] : route_dir_q[gi];
        assign has_route[gi] = req_head_i[gi] | route_vld_q[gi];
    end

    // rstn gates eligibility so nothing is accepted while reset is held.
    always_comb begin
        elig = '0;
        for (int d = 0; d < DIR_NUM; d++) begin
            for (int i = 0; i < LOCAL_PORT_NUM; i++) begin
                elig[d][i] = rstn && req_vld_i[i] && has_route[i]
                          && (cur_dir[i] == 2'(d))
                          && (credit_q[d] != '0)
                          && ((lock_q[d] == IDLE) || (owner_q[d] == IDX_W'(i)));
            end
        end
    end

    for (genvar gd = 0; gd < DIR_NUM; gd++) begin : g_arb
        rr_arb #(
            .WIDTH (LOCAL_PORT_NUM),
            .IDX_W (IDX_W)
        ) u_arb (
            .req_i     (elig[gd]),
            .ptr_i     (rr_ptr_q[gd]),
            .gnt_o     (gnt[gd]),
            .gnt_vld_o (gnt_vld[gd]),
            .gnt_idx_o (gnt_idx[gd])
        );
    end

    always_comb begin
        req_rdy_o = '0;
        win_head  = '0;
        win_tail  = '0;
        for (int d = 0; d < DIR_NUM; d++) begin
            req_rdy_o = req_rdy_o | gnt[d];
            for (int i = 0; i < LOCAL_PORT_NUM; i++) begin
                win_head[d] = win_head[d] | (gnt[d][i] & req_head_i[i]);
                win_tail[d] = win_tail[d] | (gnt[d][i] & req_tail_i[i]);
            end
        end
    end

    always_comb begin
        route_vld_d = route_vld_q;
        route_dir_d = route_dir_q;
        for (int i = 0; i < LOCAL_PORT_NUM; i++) begin
            if (req_rdy_o[i]) begin
                if (req_head_i[i] && !req_tail_i[i]) begin
                    route_vld_d[i] = 1'b1;
                    route_dir_d[i] = head_dir[i];
                end else if (req_tail_i[i]) begin
                    route_vld_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        lock_d    = lock_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        credit_d  = credit_q;
        out_vld_d = gnt_vld;
        out_sel_d = out_sel_q;
        for (int d = 0; d < DIR_NUM; d++) begin
            if (gnt_vld[d]) begin
                out_sel_d[d] = gnt_idx[d];
                if (lock_q[d] == IDLE) begin
                    rr_ptr_d[d] = rr_next(gnt_idx[d], LOCAL_PORT_NUM);
                    if (win_head[d] && !win_tail[d]) begin
                        lock_d[d]  = LOCKED;
                        owner_d[d] = gnt_idx[d];
                    end
                end else if (win_tail[d]) begin
                    lock_d[d] = IDLE;
                end
            end
            // A return landing on a full counter is dropped (saturation).
            case ({gnt_vld[d], credit_rtn_i[d]})
                2'b10:   credit_d[d] = credit_q[d] - CRD_ONE;
                2'b01:   if (credit_q[d] != CRD_MAX) credit_d[d] = credit_q[d] + CRD_ONE;
                default: credit_d[d] = credit_q[d];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            route_vld_q <= '0;
            route_dir_q <= '0;
            lock_q      <= {DIR_NUM{IDLE}};
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            credit_q    <= {DIR_NUM{CRD_MAX}};
            out_vld_q   <= '0;
            out_sel_q   <= '0;
        end else begin
            route_vld_q <= route_vld_d;
            route_dir_q <= route_dir_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            credit_q    <= credit_d;
            out_vld_q   <= out_vld_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_vld_o = out_vld_q;
    assign out_sel_o = out_sel_q;

    for (genvar ga = 0; ga < LOCAL_PORT_NUM; ga++) begin : g_route_chk
        a_body_has_route: assert property (@(posedge clk) disable iff (!rstn)
            (req_vld_i[ga] && !req_head_i[ga]) |-> route_vld_q[ga])
            else $error("non-head flit on local port %0d without a stored route", ga);
    end

    for (genvar gc = 0; gc < DIR_NUM; gc++) begin : g_credit_chk
        a_credit_ovf: assert property (@(posedge clk) disable iff (!rstn)
            !(credit_rtn_i[gc] && !gnt_vld[gc] && (credit_q[gc] == CRD_MAX)))
            else $warning("credit return on full direction %0d ignored", gc);
    end

endmodule

// File: tb/tb_local_port_sa_scheduler.sv
// Directed bench for local_port_sa_scheduler: router at (1,1), two local
// ports, four credits per direction; registered outputs checked via scoreboard.
module tb_local_port_sa_scheduler;

    localparam int P  = 2;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int IW = 2;
    localparam int DN = 0;
    localparam int DS = 1;
    localparam int DE = 2;
    localparam int DW = 3;
    localparam int SRC_X = 1;
    localparam int SRC_Y = 1;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [XW-1:0]  node_id_x_src_i = XW'(SRC_X);
    logic [YW-1:0]  node_id_y_src_i = YW'(SRC_Y);
    logic [P-1:0]   req_vld_i = '0;
    logic [P-1:0]   req_head_i = '0;
    logic [P-1:0]   req_tail_i = '0;
    logic [P*XW-1:0] req_tgt_x_i = '0;
    logic [P*YW-1:0] req_tgt_y_i = '0;
    logic [P-1:0]   req_rdy_o;
    logic [3:0]     credit_rtn_i = '0;
    logic [3:0]     out_vld_o;
    logic [4*IW-1:0] out_sel_o;

    local_port_sa_scheduler #(
        .LOCAL_PORT_NUM (P),
        .CREDIT_DEPTH   (4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .node_id_x_src_i (node_id_x_src_i),
        .node_id_y_src_i (node_id_y_src_i),
        .req_vld_i       (req_vld_i),
        .req_head_i      (req_head_i),
        .req_tail_i      (req_tail_i),
        .req_tgt_x_i     (req_tgt_x_i),
        .req_tgt_y_i     (req_tgt_y_i),
        .req_rdy_o       (req_rdy_o),
        .credit_rtn_i    (credit_rtn_i),
        .out_vld_o       (out_vld_o),
        .out_sel_o       (out_sel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dir;
        int sel;
    } exp_t;

    exp_t sb[$];
    int   tb_route [P];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic int xy_dir(input int tx, input int ty);
        if (SRC_X < tx) return DE;
        if (SRC_X > tx) return DW;
        if (SRC_Y < ty) return DN;
        return DS;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drives one cycle, checks the
    // combinational accept, then the registered outputs after the next edge.
    task automatic step(input string tag, input logic [1:0] vld, input logic [1:0] hd,
                        input logic [1:0] tl, input int tx0, input int ty0,
                        input int tx1, input int ty1, input logic [3:0] rtn,
                        input logic [1:0] exp_rdy);
        logic [3:0] exp_vld;
        int tx [P];
        int ty [P];
        tx[0] = tx0; ty[0] = ty0; tx[1] = tx1; ty[1] = ty1;
        req_vld_i    = vld;
        req_head_i   = hd;
        req_tail_i   = tl;
        req_tgt_x_i  = {XW'(tx1), XW'(tx0)};
        req_tgt_y_i  = {YW'(ty1), YW'(ty0)};
        credit_rtn_i = rtn;
        #3;
        check({tag, "/rdy"}, 32'(req_rdy_o), 32'(exp_rdy));
        for (int i = 0; i < P; i++) begin
            if (exp_rdy[i]) begin
                int d;
                d = hd[i] ? xy_dir(tx[i], ty[i]) : tb_route[i];
                if (hd[i] && !tl[i]) tb_route[i] = d;
                sb.push_back('{dir: d, sel: i});
            end
        end
        @(posedge clk);
        #1;
        exp_vld = '0;
        foreach (sb[k]) exp_vld[sb[k].dir] = 1'b1;
        check({tag, "/vld"}, 32'(out_vld_o), 32'(exp_vld));
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({tag, "/sel"}, 32'(out_sel_o[e.dir*IW +: IW]), 32'(e.sel));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < P; i++) tb_route[i] = 0;

        // Requests during reset must not be accepted.
        req_vld_i = 2'b01; req_head_i = 2'b01; req_tail_i = 2'b01;
        req_tgt_x_i = {XW'(0), XW'(3)}; req_tgt_y_i = {YW'(0), YW'(1)};
        #7;
        check("rst/rdy", 32'(req_rdy_o), 32'd0);
        check("rst/vld", 32'(out_vld_o), 32'd0);
        check("rst/sel", 32'(out_sel_o), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single-flit East, then steer rr_ptr[E] back to 0 and refill credit.
        step("e_single", 2'b01, 2'b01, 2'b01, 3, 1, 0, 0, 4'b0000, 2'b01);
        step("e_r1",     2'b10, 2'b10, 2'b10, 0, 0, 3, 1, 4'b0100, 2'b10);
        step("e_idle",   2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0100, 2'b00);

        // Both ports stream single-flit packets North with credits returned.
        step("n_rr0", 2'b11, 2'b11, 2'b11, 1, 3, 1, 3, 4'b0001, 2'b01);
        step("n_rr1", 2'b11, 2'b11, 2'b11, 1, 3, 1, 3, 4'b0001, 2'b10);
        step("n_rr2", 2'b11, 2'b11, 2'b11, 1, 3, 1, 3, 4'b0001, 2'b01);
        step("n_rr3", 2'b11, 2'b11, 2'b11, 1, 3, 1, 3, 4'b0001, 2'b10);

        // 3-flit packet East locks out port 1 until its tail.
        step("lk_head", 2'b11, 2'b11, 2'b10, 3, 1, 2, 2, 4'b0100, 2'b01);
        step("lk_body", 2'b11, 2'b10, 2'b10, 0, 0, 2, 2, 4'b0100, 2'b01);
        step("lk_tail", 2'b11, 2'b10, 2'b11, 0, 0, 2, 2, 4'b0100, 2'b01);
        step("lk_r1",   2'b10, 2'b10, 2'b10, 0, 0, 2, 2, 4'b0100, 2'b10);

        // West with no returns: four grants, stall, then one late credit.
        for (int k = 0; k < 4; k++)
            step("w_crd", 2'b01, 2'b01, 2'b01, 0, 1, 0, 0, 4'b0000, 2'b01);
        step("w_empty", 2'b01, 2'b01, 2'b01, 0, 1, 0, 0, 4'b0000, 2'b00);
        step("w_rtn",   2'b01, 2'b01, 2'b01, 0, 1, 0, 0, 4'b1000, 2'b00);
        step("w_5th",   2'b01, 2'b01, 2'b01, 0, 1, 0, 0, 4'b0000, 2'b01);
        step("w_done",  2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0000, 2'b00);

        // South: includes same-router target, grant+return at credit 2.
        step("s_g1",   2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b01);
        step("s_same", 2'b10, 2'b10, 2'b10, 0, 0, 1, 1, 4'b0000, 2'b10);
        step("s_gr",   2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0010, 2'b01);
        step("s_g3",   2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b01);
        step("s_g4",   2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b01);
        step("s_empty",2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b00);
        for (int k = 0; k < 5; k++)
            step("s_refill", 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 4'b0010, 2'b00);
        for (int k = 0; k < 4; k++)
            step("s_sat", 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b01);
        step("s_sat_empty", 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 4'b0000, 2'b00);

        // Reset in the middle of a locked 4-flit North packet.
        step("r_head", 2'b11, 2'b11, 2'b10, 1, 3, 1, 2, 4'b0000, 2'b01);
        step("r_body", 2'b11, 2'b10, 2'b10, 0, 0, 1, 2, 4'b0000, 2'b01);
        req_vld_i = 2'b10; req_head_i = 2'b10; req_tail_i = 2'b10;
        rstn = 1'b0;
        #1;
        check("rmid/vld", 32'(out_vld_o), 32'd0);
        check("rmid/sel", 32'(out_sel_o), 32'd0);
        check("rmid/rdy", 32'(req_rdy_o), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++)
            step("r_after", 2'b10, 2'b10, 2'b10, 0, 0, 1, 2, 4'b0000, 2'b10);
        step("r_after_empty", 2'b10, 2'b10, 2'b10, 0, 0, 1, 2, 4'b0000, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
